// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bus bundle shared by the arbiter's requesters and slave.
// dat_o carries write data from the master, dat_i carries read data back.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, sel, adr, dat_o,
        input  dat_i, ack, stall
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_o,
        output dat_i, ack, stall
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin arbiter for one pipelined Wishbone slave. The grant is
// held for a whole cyc; transfers still in flight are drained before handover.
module wb_arbiter2 #(
    parameter int unsigned MAX_OUT       = 4,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        m0,
    if_wb.slave        m1,
    if_wb.master       s,
    output logic [1:0] grant,
    output logic       err
);
    // state | meaning
    // IDLE  | no owner; both masters stalled; arbitrate pending requests
    // BUS0  | m0 owns the slave port
    // BUS1  | m1 owns the slave port
    // DRAIN | owner dropped cyc with transfers in flight; absorb their acks

    localparam int unsigned   TW       = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [3:0]    CNT_MAX  = 4'(MAX_OUT);
    localparam logic [TW-1:0] TMR_LOAD = TW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS0, S_BUS1, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [3:0]    out_cnt_q, out_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    logic          req0, req1, full, pending, accept, sel1;
    logic [3:0]    cnt_upd;

    assign req0    = m0.cyc & m0.stb;
    assign req1    = m1.cyc & m1.stb;
    assign full    = (out_cnt_q == CNT_MAX);
    assign pending = (out_cnt_q != 4'd0);
    assign accept  = s.stb & ~s.stall;
    assign grant   = grant_q;
    assign err     = err_q;

    // Slave cyc stays up while transfers are in flight so the owner's cyc drop
    // never aborts them before DRAIN takes over.
    always_comb begin
        sel1     = (state_q == S_BUS1);
        s.we     = sel1 ? m1.we    : m0.we;
        s.sel    = sel1 ? m1.sel   : m0.sel;
        s.adr    = sel1 ? m1.adr   : m0.adr;
        s.dat_o  = sel1 ? m1.dat_o : m0.dat_o;
        m0.dat_i = s.dat_i;
        m1.dat_i = s.dat_i;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        m0.ack   = 1'b0;
        m0.stall = 1'b1;
        m1.ack   = 1'b0;
        m1.stall = 1'b1;
        case (state_q)
            S_BUS0: begin
                s.cyc    = m0.cyc | pending;
                s.stb    = m0.cyc & m0.stb & ~full;
                m0.ack   = s.ack;
                m0.stall = s.stall | full;
            end
            S_BUS1: begin
                s.cyc    = m1.cyc | pending;
                s.stb    = m1.cyc & m1.stb & ~full;
                m1.ack   = s.ack;
                m1.stall = s.stall | full;
            end
            S_DRAIN: s.cyc = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        if (accept && !s.ack)
            cnt_upd = out_cnt_q + 4'd1;
        else if (!accept && s.ack && pending)
            cnt_upd = out_cnt_q - 4'd1;
        else
            cnt_upd = out_cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        out_cnt_d = out_cnt_q;
        timer_d   = timer_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = S_BUS0;
                    grant_d = 2'b01;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = S_BUS1;
                    grant_d = 2'b10;
                    last_d  = 1'b1;
                end
            end
            S_BUS0, S_BUS1: begin
                out_cnt_d = cnt_upd;
                if ((state_q == S_BUS0) ? !m0.cyc : !m1.cyc) begin
                    grant_d = 2'b00;
                    timer_d = TMR_LOAD;
                    state_d = (cnt_upd == 4'd0) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_cnt_d = cnt_upd;
                if (cnt_upd == 4'd0) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    state_d   = S_IDLE;
                    out_cnt_d = 4'd0;
                    err_d     = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            out_cnt_q <= 4'd0;
            timer_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            out_cnt_q <= out_cnt_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
        end
    end
endmodule
